// File: rtl/serial_sync_tx.sv
// serial_sync_tx: serial frame transmitter (sync word, payload MSB-first, optional even parity, idle gap)
// clk, rst (async, active-high) | in_valid, in_data, in_ready: payload handshake
// tx_bit, tx_en: serial bit and frame-bit qualifier | busy: frame or gap | frame_done: pulse on return to IDLE
module serial_sync_tx #(
  parameter int DATA_W = 8,
  parameter int SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC = 4'b1010,
  parameter int PARITY_EN = 1,
  parameter int GAP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              busy,
  output logic              frame_done
);
  localparam int L = SYNC_W + DATA_W + 1;
  localparam int MX = SYNC_W > DATA_W ? (SYNC_W > GAP_W ? SYNC_W : GAP_W)
                                      : (DATA_W > GAP_W ? DATA_W : GAP_W);
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [CW-1:0] SL = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DL = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GL = CW'(GAP_W > 0 ? GAP_W - 1 : 0);
  typedef enum logic [2:0] {IDLE, SYNC_S, DATA_S, PAR_S, GAP_S} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [L-1:0] sr, frame;
  logic fin;
  // Whole frame lives in one shift register; the parity slot simply never leaves when parity is off.
  assign frame = {SYNC, in_data, ^in_data};
  always_comb fin = state == PAR_S || (state == DATA_S && cnt == DL && PARITY_EN == 0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      tx_bit     <= 1'b0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      tx_bit     <= sr[L-1];
      sr         <= sr << 1;
      cnt        <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt    <= '0;
          tx_bit <= in_valid & frame[L-1];
          if (in_valid) begin
            state    <= SYNC_S;
            sr       <= frame << 1;
            tx_en    <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        SYNC_S: if (cnt == SL) begin
          state <= DATA_S;
          cnt   <= '0;
        end
        DATA_S: if (cnt == DL) begin
          state <= PAR_S;
          cnt   <= '0;
        end
        PAR_S: ;
        GAP_S: begin
          tx_bit <= 1'b0;
          if (cnt == GL) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          sr       <= '0;
          tx_bit   <= 1'b0;
          tx_en    <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
      // Last frame bit: drop into the gap, or straight to IDLE when there is none.
      if (fin) begin
        cnt        <= '0;
        tx_bit     <= 1'b0;
        tx_en      <= 1'b0;
        state      <= GAP_W > 0 ? GAP_S : IDLE;
        busy       <= GAP_W > 0;
        in_ready   <= GAP_W == 0;
        frame_done <= GAP_W == 0;
      end
    end
  end
endmodule

// File: tb/tb_serial_sync_tx.sv
// tb_serial_sync_tx: scoreboard bench for serial_sync_tx with a 1010 detector model on each serial line
module tb_serial_sync_tx;
  logic clk = 1'b0, rst = 1'b0;
  logic iv0 = 1'b0, iv1 = 1'b0;
  logic [7:0] id0 = 8'h00, id1 = 8'h00;
  logic rdy0, bit0, en0, busy0, fd0;
  logic rdy1, bit1, en1, busy1, fd1;
  logic [3:0] syncv = 4'b1010;
  logic q0[$], q1[$];
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  serial_sync_tx u0 (.clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0), .in_ready(rdy0),
                     .tx_bit(bit0), .tx_en(en0), .busy(busy0), .frame_done(fd0));
  serial_sync_tx #(.PARITY_EN(0), .GAP_W(0)) u1 (.clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1),
                     .in_ready(rdy1), .tx_bit(bit1), .tx_en(en1), .busy(busy1), .frame_done(fd1));
  typedef enum logic [2:0] {D0, D1, D10, D101, D1010} dstate_t;
  dstate_t ds0, ds1;
  logic y0, y1;
  function automatic dstate_t dnext(input dstate_t s, input logic b);
    case (s)
      D0:      return b ? D1 : D0;
      D1:      return b ? D1 : D10;
      D10:     return b ? D101 : D0;
      D101:    return b ? D1 : D1010;
      default: return b ? D101 : D0;
    endcase
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) ds0 <= D0;
    else ds0 <= dnext(ds0, bit0);
  always_ff @(posedge clk or posedge rst)
    if (rst) ds1 <= D0;
    else ds1 <= dnext(ds1, bit1);
  assign y0 = ds0 == D1010;
  assign y1 = ds1 == D1010;
  task automatic push0(input logic [7:0] d);
    for (int i = 3; i >= 0; i--) q0.push_back(syncv[i]);
    for (int i = 7; i >= 0; i--) q0.push_back(d[i]);
    q0.push_back(^d);
  endtask
  task automatic push1(input logic [7:0] d);
    for (int i = 3; i >= 0; i--) q1.push_back(syncv[i]);
    for (int i = 7; i >= 0; i--) q1.push_back(d[i]);
  endtask
  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    total++; if (bit0 !== 1'b0) $display("FAIL reset.tx_bit got=%b exp=0", bit0); else pass++;
    total++; if (en0 !== 1'b0) $display("FAIL reset.tx_en got=%b exp=0", en0); else pass++;
    total++; if (busy0 !== 1'b0) $display("FAIL reset.busy got=%b exp=0", busy0); else pass++;
    total++; if (fd0 !== 1'b0) $display("FAIL reset.frame_done got=%b exp=0", fd0); else pass++;
    total++; if (rdy0 !== 1'b1) $display("FAIL reset.in_ready got=%b exp=1", rdy0); else pass++;
    total++; if ({rdy1, en1, busy1} !== 3'b100) $display("FAIL reset.u1 got=%b exp=100", {rdy1, en1, busy1}); else pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_single;
    logic b;
    id0 = 8'hC5; iv0 = 1'b1; push0(8'hC5);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin iv0 = 1'b0; id0 = 8'h3A; end
      b = k <= 13 ? (q0.size() > 0 ? q0.pop_front() : 1'bx) : 1'b0;
      total++; if (bit0 !== b) $display("FAIL single.tx_bit k=%0d got=%b exp=%b", k, bit0, b); else pass++;
      total++; if (en0 !== (k <= 13)) $display("FAIL single.tx_en k=%0d got=%b exp=%b", k, en0, k <= 13); else pass++;
      total++; if (busy0 !== (k <= 15)) $display("FAIL single.busy k=%0d got=%b exp=%b", k, busy0, k <= 15); else pass++;
      total++; if (fd0 !== (k == 16)) $display("FAIL single.frame_done k=%0d got=%b exp=%b", k, fd0, k == 16); else pass++;
      total++; if (rdy0 !== (k == 16)) $display("FAIL single.in_ready k=%0d got=%b exp=%b", k, rdy0, k == 16); else pass++;
    end
  endtask
  task automatic test_back_to_back;
    logic b, e;
    int nfd = 0;
    id0 = 8'h01; iv0 = 1'b1; push0(8'h01);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      e = k <= 13 || (k >= 17 && k <= 29);
      b = e ? (q0.size() > 0 ? q0.pop_front() : 1'bx) : 1'b0;
      nfd += int'(fd0);
      total++; if (bit0 !== b) $display("FAIL b2b.tx_bit k=%0d got=%b exp=%b", k, bit0, b); else pass++;
      total++; if (en0 !== e) $display("FAIL b2b.tx_en k=%0d got=%b exp=%b", k, en0, e); else pass++;
      total++; if (fd0 !== (k == 16 || k == 32)) $display("FAIL b2b.frame_done k=%0d got=%b", k, fd0); else pass++;
      if (k == 16) begin id0 = 8'h5A; push0(8'h5A); end
      if (k == 32) iv0 = 1'b0;
    end
    total++; if (nfd != 2) $display("FAIL b2b.pulses got=%0d exp=2", nfd); else pass++;
  endtask
  task automatic test_busy_ignore;
    logic b;
    id0 = 8'h3C; iv0 = 1'b1; push0(8'h3C);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) iv0 = 1'b0;
      b = k <= 13 ? (q0.size() > 0 ? q0.pop_front() : 1'bx) : 1'b0;
      total++; if (bit0 !== b) $display("FAIL ignore.tx_bit k=%0d got=%b exp=%b", k, bit0, b); else pass++;
      total++; if (en0 !== (k <= 13)) $display("FAIL ignore.tx_en k=%0d got=%b", k, en0); else pass++;
      total++; if (rdy0 !== (k >= 16)) $display("FAIL ignore.in_ready k=%0d got=%b exp=%b", k, rdy0, k >= 16); else pass++;
      total++; if (busy0 !== (k <= 15)) $display("FAIL ignore.busy k=%0d got=%b", k, busy0); else pass++;
      if (k == 6) begin iv0 = 1'b1; id0 = 8'hFF; end
      if (k == 7) iv0 = 1'b0;
    end
    total++; if (q0.size() != 0) $display("FAIL ignore.leftover got=%0d exp=0", q0.size()); else pass++;
  endtask
  task automatic test_abort;
    logic b;
    id0 = 8'hA7; iv0 = 1'b1; push0(8'hA7);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) iv0 = 1'b0;
      b = q0.size() > 0 ? q0.pop_front() : 1'bx;
      total++; if (bit0 !== b) $display("FAIL abort.pre_bit k=%0d got=%b exp=%b", k, bit0, b); else pass++;
    end
    #1 rst = 1'b1;
    #1;
    total++; if ({bit0, en0, busy0, fd0, rdy0} !== 5'b00001) $display("FAIL abort.outputs got=%b exp=00001", {bit0, en0, busy0, fd0, rdy0}); else pass++;
    @(negedge clk);
    total++; if (fd0 !== 1'b0) $display("FAIL abort.frame_done got=%b exp=0", fd0); else pass++;
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    id0 = 8'h96; iv0 = 1'b1; push0(8'h96);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) iv0 = 1'b0;
      b = k <= 13 ? (q0.size() > 0 ? q0.pop_front() : 1'bx) : 1'b0;
      total++; if (bit0 !== b) $display("FAIL abort.tx_bit k=%0d got=%b exp=%b", k, bit0, b); else pass++;
      total++; if (en0 !== (k <= 13)) $display("FAIL abort.tx_en k=%0d got=%b", k, en0); else pass++;
      total++; if (fd0 !== (k == 16)) $display("FAIL abort.frame_done k=%0d got=%b", k, fd0); else pass++;
    end
  endtask
  task automatic test_loopback;
    logic b, e;
    id0 = 8'h00; iv0 = 1'b1; push0(8'h00);
    id1 = 8'h00; iv1 = 1'b1; push1(8'h00);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 1) iv0 = 1'b0;
      if (k <= 13) begin
        b = q0.size() > 0 ? q0.pop_front() : 1'bx;
        total++; if (bit0 !== b) $display("FAIL loop.u0_bit k=%0d got=%b exp=%b", k, bit0, b); else pass++;
      end
      total++; if (y0 !== (k == 5)) $display("FAIL loop.u0_y k=%0d got=%b exp=%b", k, y0, k == 5); else pass++;
      e = k <= 12 || (k >= 14 && k <= 25);
      b = e ? (q1.size() > 0 ? q1.pop_front() : 1'bx) : 1'b0;
      total++; if (bit1 !== b) $display("FAIL loop.u1_bit k=%0d got=%b exp=%b", k, bit1, b); else pass++;
      total++; if (en1 !== e) $display("FAIL loop.u1_en k=%0d got=%b exp=%b", k, en1, e); else pass++;
      total++; if (fd1 !== (k == 13 || k == 26)) $display("FAIL loop.u1_done k=%0d got=%b", k, fd1); else pass++;
      total++; if (y1 !== (k == 5 || k == 18)) $display("FAIL loop.u1_y k=%0d got=%b", k, y1); else pass++;
      if (k == 13) push1(8'h00);
      if (k == 26) iv1 = 1'b0;
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_busy_ignore;
    test_abort;
    test_loopback;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
